// File: rtl/mem_operand_fetch.sv
// ============================================================================
// Module   : mem_operand_fetch
// Brief    : Fetches two operands from a sync-read data memory for the ALU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_operand_fetch #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int SEL_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_dir1,
    input  logic [ADDR_W-1:0] req_dir2,
    input  logic [SEL_W-1:0]  req_sel,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_dir,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_op1,
    output logic [DATA_W-1:0] out_op2,
    output logic [SEL_W-1:0]  out_sel,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD1  = 3'd1,
        S_RD2  = 3'd2,
        S_WAIT = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   dir1_q, dir1_d;
    logic [ADDR_W-1:0]   dir2_q, dir2_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                same_q, same_d;
    logic [DATA_W-1:0]   op1_q, op1_d;
    logic [DATA_W-1:0]   op2_q, op2_d;
    logic                accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            dir1_q  <= '0;
            dir2_q  <= '0;
            sel_q   <= '0;
            same_q  <= 1'b0;
            op1_q   <= '0;
            op2_q   <= '0;
        end else begin
            state_q <= state_d;
            dir1_q  <= dir1_d;
            dir2_q  <= dir2_d;
            sel_q   <= sel_d;
            same_q  <= same_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        dir1_d    = dir1_q;
        dir2_d    = dir2_q;
        sel_d     = sel_q;
        same_d    = same_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        mem_rd_en = 1'b0;
        mem_dir   = '0;
        out_valid = 1'b0;

        req_ready = (state_q == S_IDLE) || ((state_q == S_OUT) && out_ready);
        accept    = req_valid && req_ready;

        // Request fields are sampled only on the accepting edge.
        if (accept) begin
            dir1_d = req_dir1;
            dir2_d = req_dir2;
            sel_d  = req_sel;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_RD1;
            end
            S_RD1: begin
                mem_rd_en = 1'b1;
                mem_dir   = dir1_q;
                same_d    = (dir1_q == dir2_q);
                state_d   = (dir1_q == dir2_q) ? S_WAIT : S_RD2;
            end
            S_RD2: begin
                mem_rd_en = 1'b1;
                mem_dir   = dir2_q;
                op1_d     = mem_dout;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                op2_d = mem_dout;
                if (same_q) op1_d = mem_dout;
                state_d = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_d = accept ? S_RD1 : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign out_op1 = op1_q;
    assign out_op2 = op2_q;
    assign out_sel = sel_q;
    assign busy    = (state_q != S_IDLE);

endmodule

`default_nettype wire
